// File: rtl/qos_aging_arbiter_pkg.sv
// rtl/qos_aging_arbiter_pkg.sv - shared state type, default constants and helpers for the QoS aging arbiter
package qos_arb_pkg;

  typedef enum logic {
    IDLE,
    LOCKED
  } state_t;

  localparam int DEF_STREAM_COUNT = 4;
  localparam int DEF_QOS_WIDTH    = 4;
  localparam int DEF_AGE_WIDTH    = 8;
  localparam int DEF_AGE_LIMIT    = 64;
  localparam int MAX_STREAMS      = 32;

  // Index of the set bit in a one-hot vector; 0 for an all-zero vector.
  function automatic int unsigned onehot_to_idx(input logic [MAX_STREAMS-1:0] oh);
    int unsigned idx;
    idx = 0;
    for (int i = 0; i < MAX_STREAMS; i++) begin
      if (oh[i]) idx = unsigned'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/qos_aging_arbiter_rr_picker.sv
// rtl/qos_aging_arbiter_rr_picker.sv - round-robin picker: first candidate strictly after the pointer
module rr_picker #(
  parameter int N = 4
) (
  input  logic [N-1:0]         candidates,
  input  logic [$clog2(N)-1:0] pointer,
  output logic [N-1:0]         winner,
  output logic                 valid
);

  localparam int PW = $clog2(N);

  logic          found;
  logic [PW-1:0] sel;

  // Scan offsets 1..N so the stream at the pointer itself is considered last.
  always_comb begin
    winner = '0;
    found  = 1'b0;
    sel    = '0;
    for (int k = 1; k <= N; k++) begin
      sel = PW'((int'(pointer) + k) % N);
      if (!found && candidates[sel]) begin
        winner[sel] = 1'b1;
        found       = 1'b1;
      end
    end
  end

  assign valid = |candidates;

endmodule

// File: rtl/qos_aging_arbiter.sv
// rtl/qos_aging_arbiter.sv - packet-locked QoS arbiter with round-robin tie break and starvation aging
// Aging (wait counters, urgent promotion) is built only when QOS_ARB_AGING_EN is defined.
module qos_aging_arbiter
  import qos_arb_pkg::*;
#(
  parameter int STREAM_COUNT = DEF_STREAM_COUNT,
  parameter int T_QOS__WIDTH = DEF_QOS_WIDTH,
  parameter int AGE_WIDTH    = DEF_AGE_WIDTH,
  parameter int AGE_LIMIT    = DEF_AGE_LIMIT
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [STREAM_COUNT-1:0]         req,
  input  logic [STREAM_COUNT-1:0]         last,
  input  logic [T_QOS__WIDTH-1:0]         qos [STREAM_COUNT],
  input  logic                            en,
  output logic [STREAM_COUNT-1:0]         grant,
  output logic [$clog2(STREAM_COUNT)-1:0] grant_idx,
  output logic                            busy,
  output logic                            urgent
);

  localparam int IW = $clog2(STREAM_COUNT);

  if (STREAM_COUNT < 2 || STREAM_COUNT > MAX_STREAMS ||
      AGE_LIMIT < 1 || AGE_LIMIT >= (1 << AGE_WIDTH)) begin : g_bad_cfg
    $error("qos_aging_arbiter: illegal parameter combination");
  end

  state_t                  state;
  logic [IW-1:0]           rr_ptr;
  logic [T_QOS__WIDTH-1:0] max_qos;
  logic [STREAM_COUNT-1:0] qos_cand;
  logic [STREAM_COUNT-1:0] urgent_set;
  logic [STREAM_COUNT-1:0] cand;
  logic [STREAM_COUNT-1:0] winner;
  logic [IW-1:0]           win_idx;
  logic                    win_valid;
  logic                    use_urgent;
  logic                    release_now;
  logic                    arb_now;
  logic                    load;

  always_comb begin
    max_qos = '0;
    for (int i = 0; i < STREAM_COUNT; i++) begin
      if (req[i] && qos[i] > max_qos) max_qos = qos[i];
    end
  end

  // QoS 0 is a wildcard: such a stream competes in every round-robin pass.
  always_comb begin
    qos_cand = '0;
    for (int i = 0; i < STREAM_COUNT; i++) begin
      qos_cand[i] = req[i] && (qos[i] == max_qos || qos[i] == '0);
    end
  end

`ifdef QOS_ARB_AGING_EN
  localparam logic [AGE_WIDTH-1:0] CNT_MAX = '1;
  localparam logic [AGE_WIDTH-1:0] LIMIT   = AGE_WIDTH'(AGE_LIMIT);

  logic [AGE_WIDTH-1:0] wait_cnt [STREAM_COUNT];

  always_ff @(posedge clk) begin
    for (int i = 0; i < STREAM_COUNT; i++) begin
      if (rst || !req[i] || grant[i] || (load && winner[i])) begin
        wait_cnt[i] <= '0;
      end else if (wait_cnt[i] != CNT_MAX) begin
        wait_cnt[i] <= wait_cnt[i] + AGE_WIDTH'(1);
      end
    end
  end

  always_comb begin
    urgent_set = '0;
    for (int i = 0; i < STREAM_COUNT; i++) begin
      urgent_set[i] = req[i] && (wait_cnt[i] >= LIMIT);
    end
  end
`else
  assign urgent_set = '0;
`endif

  assign use_urgent = |urgent_set;
  assign cand       = use_urgent ? urgent_set : qos_cand;

  rr_picker #(
    .N (STREAM_COUNT)
  ) u_rr_picker (
    .candidates (cand),
    .pointer    (rr_ptr),
    .winner     (winner),
    .valid      (win_valid)
  );

  assign win_idx = IW'(onehot_to_idx(MAX_STREAMS'(winner)));

  // A granted stream dropping req counts as an abort and frees the output.
  assign release_now = (state == LOCKED) &&
                       (!req[grant_idx] || (en && last[grant_idx]));
  assign arb_now     = (state == IDLE) || release_now;
  assign load        = arb_now && win_valid;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      grant     <= '0;
      grant_idx <= '0;
      busy      <= 1'b0;
      urgent    <= 1'b0;
      rr_ptr    <= IW'(STREAM_COUNT - 1);
    end else if (load) begin
      state     <= LOCKED;
      grant     <= winner;
      grant_idx <= win_idx;
      busy      <= 1'b1;
      urgent    <= use_urgent;
      rr_ptr    <= win_idx;
    end else if (arb_now) begin
      state     <= IDLE;
      grant     <= '0;
      grant_idx <= '0;
      busy      <= 1'b0;
      urgent    <= 1'b0;
    end
  end

endmodule

// File: tb/tb_qos_aging_arbiter.sv
// tb/tb_qos_aging_arbiter.sv - scoreboard bench for qos_aging_arbiter (4 streams, AGE_LIMIT 8)
module tb_qos_aging_arbiter;

  localparam bit AGING =
`ifdef QOS_ARB_AGING_EN
    1'b1;
`else
    1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [3:0] req = '0;
  logic [3:0] last = '0;
  logic [3:0] qos [4];
  logic       en = 1'b0;
  logic [3:0] grant;
  logic [1:0] grant_idx;
  logic       busy;
  logic       urgent;

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0] exp_q [$];

  qos_aging_arbiter #(
    .STREAM_COUNT (4),
    .T_QOS__WIDTH (4),
    .AGE_WIDTH    (8),
    .AGE_LIMIT    (8)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .last      (last),
    .qos       (qos),
    .en        (en),
    .grant     (grant),
    .grant_idx (grant_idx),
    .busy      (busy),
    .urgent    (urgent)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] mk(logic [3:0] g, logic [1:0] i, logic b, logic u);
    return {g, i, b, u};
  endfunction

  function automatic logic [7:0] obs();
    return {grant, grant_idx, busy, urgent};
  endfunction

  // qv packs {qos3, qos2, qos1, qos0}; the expected outcome after the next edge is queued.
  task automatic drive(input logic [3:0] r, input logic [3:0] l, input logic e,
                       input logic [15:0] qv, input logic [7:0] ex);
    req  = r;
    last = l;
    en   = e;
    for (int i = 0; i < 4; i++) qos[i] = qv[i*4 +: 4];
    exp_q.push_back(ex);
  endtask

  task automatic do_reset();
    rst  = 1'b1;
    req  = '0;
    last = '0;
    en   = 1'b0;
    for (int i = 0; i < 4; i++) qos[i] = '0;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    logic [7:0] e;
    rst = 1'b1;
    drive(4'b1111, 4'b1111, 1'b1, 16'h5555, mk(4'b0000, 2'd0, 1'b0, 1'b0));
    @(posedge clk); #1;
    rst = 1'b0;
    e = exp_q.pop_front();
    n_tests++;
    if (obs() !== e) begin
      n_fail++;
      $display("FAIL reset: got %b expected %b", obs(), e);
    end
  endtask

  task automatic test_qos_hold();
    logic [7:0] e;
    do_reset();
    for (int s = 0; s < 5; s++) begin
      case (s)
        0: drive(4'b0110, 4'b0000, 1'b0, 16'h0730, mk(4'b0100, 2'd2, 1'b1, 1'b0));
        1: drive(4'b0110, 4'b0000, 1'b1, 16'h0730, mk(4'b0100, 2'd2, 1'b1, 1'b0));
        2: drive(4'b0110, 4'b0000, 1'b1, 16'h0730, mk(4'b0100, 2'd2, 1'b1, 1'b0));
        3: drive(4'b0110, 4'b0100, 1'b1, 16'h0790, mk(4'b0010, 2'd1, 1'b1, 1'b0));
        default: drive(4'b0000, 4'b0000, 1'b0, 16'h0000, mk(4'b0000, 2'd0, 1'b0, 1'b0));
      endcase
      @(posedge clk); #1;
      e = exp_q.pop_front();
      n_tests++;
      if (obs() !== e) begin
        n_fail++;
        $display("FAIL qos_hold step %0d: got %b expected %b", s, obs(), e);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] e;
    logic [1:0] idx;
    do_reset();
    for (int s = 0; s < 6; s++) begin
      idx = 2'(s % 4);
      if (s < 5) drive(4'b1111, 4'b1111, 1'b1, 16'h5555, mk(4'b0001 << idx, idx, 1'b1, 1'b0));
      else       drive(4'b0000, 4'b0000, 1'b0, 16'h5555, mk(4'b0000, 2'd0, 1'b0, 1'b0));
      @(posedge clk); #1;
      e = exp_q.pop_front();
      n_tests++;
      if (obs() !== e) begin
        n_fail++;
        $display("FAIL back_to_back step %0d: got %b expected %b", s, obs(), e);
      end
    end
  endtask

  task automatic test_qos_zero();
    logic [7:0] e;
    do_reset();
    for (int s = 0; s < 3; s++) begin
      case (s)
        0: drive(4'b0010, 4'b0000, 1'b0, 16'h0090, mk(4'b0010, 2'd1, 1'b1, 1'b0));
        1: drive(4'b0011, 4'b0010, 1'b1, 16'h0090, mk(4'b0001, 2'd0, 1'b1, 1'b0));
        default: drive(4'b0000, 4'b0000, 1'b0, 16'h0090, mk(4'b0000, 2'd0, 1'b0, 1'b0));
      endcase
      @(posedge clk); #1;
      e = exp_q.pop_front();
      n_tests++;
      if (obs() !== e) begin
        n_fail++;
        $display("FAIL qos_zero step %0d: got %b expected %b", s, obs(), e);
      end
    end
  endtask

  task automatic test_abort();
    logic [7:0] e;
    do_reset();
    for (int s = 0; s < 5; s++) begin
      case (s)
        0: drive(4'b0100, 4'b0000, 1'b0, 16'h5555, mk(4'b0100, 2'd2, 1'b1, 1'b0));
        1: drive(4'b0110, 4'b0000, 1'b1, 16'h5555, mk(4'b0100, 2'd2, 1'b1, 1'b0));
        2: drive(4'b0010, 4'b0000, 1'b0, 16'h5555, mk(4'b0010, 2'd1, 1'b1, 1'b0));
        3: drive(4'b0000, 4'b0000, 1'b0, 16'h5555, mk(4'b0000, 2'd0, 1'b0, 1'b0));
        default: drive(4'b0000, 4'b1111, 1'b1, 16'h5555, mk(4'b0000, 2'd0, 1'b0, 1'b0));
      endcase
      @(posedge clk); #1;
      e = exp_q.pop_front();
      n_tests++;
      if (obs() !== e) begin
        n_fail++;
        $display("FAIL abort step %0d: got %b expected %b", s, obs(), e);
      end
    end
  endtask

  task automatic test_reset_midpacket();
    logic [7:0] e;
    do_reset();
    for (int s = 0; s < 3; s++) begin
      rst = (s == 1);
      case (s)
        0: drive(4'b0100, 4'b0000, 1'b0, 16'h5555, mk(4'b0100, 2'd2, 1'b1, 1'b0));
        1: drive(4'b0100, 4'b0000, 1'b1, 16'h5555, mk(4'b0000, 2'd0, 1'b0, 1'b0));
        default: drive(4'b1010, 4'b0000, 1'b0, 16'h5555, mk(4'b0010, 2'd1, 1'b1, 1'b0));
      endcase
      @(posedge clk); #1;
      rst = 1'b0;
      e = exp_q.pop_front();
      n_tests++;
      if (obs() !== e) begin
        n_fail++;
        $display("FAIL reset_midpacket step %0d: got %b expected %b", s, obs(), e);
      end
    end
  endtask

  task automatic test_aging();
    logic [7:0] e;
    do_reset();
    for (int s = 0; s < 11; s++) begin
      if (s == 10)
        drive(4'b0000, 4'b0000, 1'b0, 16'hF001, mk(4'b0000, 2'd0, 1'b0, 1'b0));
      else if (AGING && s >= 8)
        drive(4'b1001, 4'b1000, 1'b1, 16'hF001, mk(4'b0001, 2'd0, 1'b1, 1'b1));
      else
        drive(4'b1001, 4'b1000, 1'b1, 16'hF001, mk(4'b1000, 2'd3, 1'b1, 1'b0));
      @(posedge clk); #1;
      e = exp_q.pop_front();
      n_tests++;
      if (obs() !== e) begin
        n_fail++;
        $display("FAIL aging step %0d: got %b expected %b", s, obs(), e);
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 4; i++) qos[i] = '0;
    @(posedge clk); #1;
    test_reset();
    test_qos_hold();
    test_back_to_back();
    test_qos_zero();
    test_abort();
    test_reset_midpacket();
    test_aging();
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d entries left expected 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
